// File: rtl/swan_core_param.sv
// Iterative SWAN block cipher core: one half-round per clock, encrypt or decrypt per block,
// with a one-entry cache of the precomputed decryption key.
module swan_core_param #(
  parameter int unsigned BLOCK_SIZE = 64,
  parameter int unsigned KEY_SIZE   = 128,
  parameter int unsigned ROUNDS     = 32,
  parameter int unsigned PD         = 24,
  parameter logic [31:0] DELTA0     = 32'h9e3779b9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  mode,
  input  logic [BLOCK_SIZE-1:0] inp,
  input  logic [KEY_SIZE-1:0]   key,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BLOCK_SIZE-1:0] out,
  output logic                  busy
);
  localparam int unsigned SIDE_SIZE   = BLOCK_SIZE / 2;
  localparam int unsigned HALF_ROUNDS = 2 * ROUNDS;
  localparam int unsigned HR_W        = $clog2(HALF_ROUNDS);
  localparam logic [HR_W-1:0]      HR_LAST = HR_W'(HALF_ROUNDS - 1);
  localparam logic [SIDE_SIZE-1:0] DELTA   = SIDE_SIZE'(DELTA0);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PRECOMP = 2'd1;
  localparam logic [1:0] RUN     = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    sbox = 4'h0;
    case (x)
      4'h0: sbox = 4'hc;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hb;
      4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'ha;  4'h7: sbox = 4'hd;
      4'h8: sbox = 4'h3;  4'h9: sbox = 4'he;  4'ha: sbox = 4'hf;  4'hb: sbox = 4'h8;
      4'hc: sbox = 4'h4;  4'hd: sbox = 4'h7;  4'he: sbox = 4'h1;  4'hf: sbox = 4'h2;
      default: sbox = 4'h0;
    endcase
  endfunction

  function automatic logic [SIDE_SIZE-1:0] rotl_s(input logic [SIDE_SIZE-1:0] x,
                                                   input int unsigned n);
    return (x << n) | (x >> (SIDE_SIZE - n));
  endfunction

  function automatic logic [SIDE_SIZE-1:0] vartheta(input logic [SIDE_SIZE-1:0] x);
    return x ^ rotl_s(x, 2) ^ rotl_s(x, 7);
  endfunction

  function automatic logic [SIDE_SIZE-1:0] beta_table(input logic [SIDE_SIZE-1:0] x);
    logic [SIDE_SIZE-1:0] y;
    y = '0;
    for (int unsigned i = 0; i < SIDE_SIZE / 4; i++) y[4*i +: 4] = sbox(x[4*i +: 4]);
    return y;
  endfunction

  function automatic logic [SIDE_SIZE-1:0] rho(input logic [SIDE_SIZE-1:0] x);
    return rotl_s(x, 1) ^ rotl_s(x, 8);
  endfunction

  function automatic logic [SIDE_SIZE-1:0] f_round(input logic [SIDE_SIZE-1:0] x,
                                                    input logic [SIDE_SIZE-1:0] sk);
    return rho(vartheta(beta_table(vartheta(x) ^ sk)));
  endfunction

  logic [1:0]            state, state_nxt;
  logic [SIDE_SIZE-1:0]  l, r, rd;
  logic [KEY_SIZE-1:0]   key_w;
  logic [HR_W-1:0]       hr;
  logic                  mode_q;
  logic                  cache_valid;
  logic [KEY_SIZE-1:0]   cached_key, cached_pkey;
  logic [SIDE_SIZE-1:0]  cached_rd;

  logic                  cache_hit;
  logic [SIDE_SIZE-1:0]  enc_rd, dec_rd, rd_nxt, sk, f_out, l_nxt, r_nxt;
  logic [KEY_SIZE-1:0]   enc_key, dec_key, key_nxt;
  logic                  upd_r;

  assign cache_hit = cache_valid && (key == cached_key);

  // Forward key-schedule step and its exact inverse; decrypt walks the schedule backwards
  always_comb begin
    enc_rd = rd + DELTA;
    enc_key = (key_w >> PD) | (key_w << (KEY_SIZE - PD));
    enc_key[SIDE_SIZE-1:0] = enc_key[SIDE_SIZE-1:0] + enc_rd;
    dec_rd = rd - DELTA;
    dec_key = key_w;
    dec_key[SIDE_SIZE-1:0] = dec_key[SIDE_SIZE-1:0] - rd;
    dec_key = (dec_key << PD) | (dec_key >> (KEY_SIZE - PD));
    sk = mode_q ? dec_key[SIDE_SIZE-1:0] : key_w[SIDE_SIZE-1:0];
    key_nxt = mode_q ? dec_key : enc_key;
    rd_nxt = mode_q ? dec_rd : enc_rd;
    upd_r = hr[0] ^ mode_q;
    f_out = f_round(upd_r ? l : r, sk);
    l_nxt = upd_r ? l : (l ^ f_out);
    r_nxt = upd_r ? (r ^ f_out) : r;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = (mode && !cache_hit) ? PRECOMP : RUN;
      PRECOMP: if (hr == '0) state_nxt = RUN;
      RUN:     if (hr == '0) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      out         <= '0;
      l           <= '0;
      r           <= '0;
      rd          <= '0;
      key_w       <= '0;
      hr          <= '0;
      mode_q      <= 1'b0;
      cache_valid <= 1'b0;
      cached_key  <= '0;
      cached_pkey <= '0;
      cached_rd   <= '0;
    end else begin
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
      busy      <= (state_nxt == PRECOMP) || (state_nxt == RUN);
      case (state)
        IDLE: if (in_valid) begin
          l      <= inp[SIDE_SIZE-1:0];
          r      <= inp[BLOCK_SIZE-1:SIDE_SIZE];
          mode_q <= mode;
          hr     <= HR_LAST;
          if (mode && cache_hit) begin
            key_w <= cached_pkey;
            rd    <= cached_rd;
          end else begin
            key_w <= key;
            rd    <= '0;
          end
          if (mode && !cache_hit) begin
            cache_valid <= 1'b0;
            cached_key  <= key;
          end
        end
        PRECOMP: begin
          key_w <= enc_key;
          rd    <= enc_rd;
          if (hr == '0) begin
            hr          <= HR_LAST;
            cached_pkey <= enc_key;
            cached_rd   <= enc_rd;
            cache_valid <= 1'b1;
          end else begin
            hr <= hr - 1'b1;
          end
        end
        RUN: begin
          key_w <= key_nxt;
          rd    <= rd_nxt;
          l     <= l_nxt;
          r     <= r_nxt;
          if (hr == '0) out <= {r_nxt, l_nxt};
          else          hr  <= hr - 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/swan_core_param.md
Name: swan_core_param

Overview:
- Parametrised, iterative SWAN block-cipher core: one half-round per clock, encryption or decryption selected per block.
- Successor to the fixed 64/128 cores. Adds generic BLOCK_SIZE/KEY_SIZE, a runtime mode select, and valid/ready handshakes on both sides.
- Decryption key precomputation is sequential (one step per cycle). A cached precomputed key skips it when the key is unchanged.
- Sits between the SWAN bus wrapper and the testbench/AXI shim.

Parameters:
- BLOCK_SIZE, 64, cipher block width; SIDE_SIZE = BLOCK_SIZE/2. Legal values: 64, 128, 256.
- KEY_SIZE, 128, master key width. Must be >= BLOCK_SIZE and a multiple of SIDE_SIZE.
- ROUNDS, 32, full rounds; HALF_ROUNDS = 2*ROUNDS.
- PD, 24, key-schedule rotate amount in bits.
- DELTA0, 32'h9e3779b9, round-delta increment, zero/sign-extended to SIDE_SIZE.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous reset, active-high.
- in_valid, input, 1, block/key/mode presented.
- in_ready, output, 1, core can accept.
- mode, input, 1, 0 = encrypt, 1 = decrypt; sampled on accept.
- inp, input, BLOCK_SIZE, input block; bit 0 is MSB.
- key, input, KEY_SIZE, master key; sampled on accept.
- out_valid, output, 1, result available.
- out_ready, input, 1, consumer takes result.
- out, output, BLOCK_SIZE, result {R,L}.
- busy, output, 1, high in PRECOMP or RUN.

Behaviour:
- Reset (rst=1 at an edge):
  - FSM goes to IDLE; in_ready=1, out_valid=0, busy=0.
  - out=0; counters=0; key-cache valid flag cleared.
  - Reset wins over every other event, including mid-PRECOMP, mid-RUN and in DONE. No partial result is ever presented.
- Accept: an edge with in_valid && in_ready. Only legal in IDLE; in_ready=0 in all other states.
  - Latch L = inp[SIDE_SIZE:BLOCK_SIZE-1], R = inp[0:SIDE_SIZE-1], the mode, rd=0, and the working key.
  - hr counter = HALF_ROUNDS-1.
- Next-state on accept:
  - Encrypt: working key = key; next state RUN.
  - Decrypt, cache hit (cache valid and key == cached_key): working key = cached precomputed key, rd = cached rd; next state RUN.
  - Decrypt, cache miss: working key = key; next state PRECOMP.
- PRECOMP, HALF_ROUNDS cycles, one step per edge:
  - rd += DELTA0.
  - key = rotr(key, PD).
  - key[KEY_SIZE-SIDE_SIZE:KEY_SIZE-1] += rd (the new rd), mod 2^SIDE_SIZE.
  - After the last step: store cached_key = original key, cached precomputed key and rd; set cache valid; go to RUN with hr = HALF_ROUNDS-1.
- RUN, HALF_ROUNDS edges:
  - F(x) = rho(vartheta(beta(vartheta(x) ^ sk))). Use the team's vartheta/beta_table/rho units instantiated at SIDE_SIZE.
  - sk, next key and next rd come from the encrypt or decrypt key-schedule step for KEY_SIZE, muxed by the latched mode.
  - Encrypt: hr odd -> R ^= F(L); hr even -> L ^= F(R).
  - Decrypt: hr odd -> L ^= F(R); hr even -> R ^= F(L).
  - Every RUN edge: key <= next key, rd <= next rd, hr -= 1.
  - The edge processing hr=0 moves to DONE.
- Latency, counted in edges after the accept edge to out_valid=1:
  - Encrypt: HALF_ROUNDS (64 at default).
  - Decrypt, cache miss: 2*HALF_ROUNDS.
  - Decrypt, cache hit: HALF_ROUNDS.
- DONE:
  - out_valid=1 and out stable until an edge with out_ready=1; that edge returns to IDLE and sets in_ready=1.
  - No combinational path from out_ready to in_ready. A new accept is possible at the earliest one edge after the handoff.
- Other rules:
  - in_valid, inp, key and mode are ignored outside IDLE.
  - Encryption never modifies the key cache.
  - hr is a $clog2(HALF_ROUNDS)-bit down-counter with no wrap-around: its transition is gated by state.

Test Plan:
- Reset behaviour: assert rst for 2 cycles mid-RUN (edge 30 of encrypt) -> next cycle in_ready=1, out_valid=0, busy=0; a following encrypt of the same vector gives the correct result after exactly 64 edges.
- Encrypt KAT, default params: inp=64'h0123456789abcdef, key=128'h0011...eeff -> out_valid at edge 64 with out equal to the golden C model; in_ready=0 throughout.
- Round-trip with cache: decrypt the above ciphertext under the same key, twice in succession -> first out_valid at edge 128, second at edge 64, both out=64'h0123456789abcdef.
- Key change invalidates the cache: decrypt under key A, then under key B -> second decrypt takes 128 edges and matches the model for B.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while toggling in_valid/inp -> out stable, in_ready=0, no accept. Release -> IDLE; the next accept processes only the new inp.
- Wide configuration: BLOCK_SIZE=128, KEY_SIZE=256 -> random encrypt/decrypt round-trips (100 vectors) match the model, with latencies 64/128/64.
